spi_target_port: RTL and testbench

SPI mode-0 target (responder) on the XT I/O bus. An external SPI controller, such as a debug MCU or a host bridge, clocks bytes into and out of the system. The CPU reads received bytes and queues reply bytes through ports 0BCh/0BDh. All SPI pins are sampled into the single system clock domain; no logic runs on the external SCK.

---
 rtl/spi_target_port.sv | 271 +++++++++++++++++++++++++++
 tb/tb_spi_target_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_port.sv
// spi_target_port -- SPI mode-0 target on the XT I/O bus.
//
// An external SPI controller shifts bytes in on MOSI and out on MISO. Every
// SPI pin is sampled into the iClk domain. No logic is clocked by SCK.
// The CPU side uses two I/O ports:
//   0BCh write : load the TX holding register (sets tx_full)
//   0BCh read  : pop the RX head (returns FFh when RX is empty)
//   0BDh read  : status {0, rx_count[2:0], cs_active, rx_overrun, ~tx_full, rx_avail}
//   0BDh write : bit0 -> irq_en, bit2=1 clears rx_overrun
//
// Ports:
//   iClk, iRstN        system clock, synchronous active-low reset
//   iAddr[19:0]        I/O address (only [11:0] decoded)
//   iWr, iRd, iData    one-cycle CPU strobes and write data
//   oData, oSel        registered read data and its valid pulse
//   iSpiSck/Mosi/CsN   asynchronous SPI pins
//   oSpiMiso/MisoOe    MISO data and output enable
//   oIrq               irq_en & rx_avail
//
// Build option: define SPI_TARGET_RXFIFO_EN for a 4-entry RX FIFO. Without it,
// RX is a single byte latch.

module spi_target_port (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [19:0] iAddr,
  input  logic        iWr,
  input  logic        iRd,
  input  logic [7:0]  iData,
  output logic [7:0]  oData,
  output logic        oSel,
  input  logic        iSpiSck,
  input  logic        iSpiMosi,
  input  logic        iSpiCsN,
  output logic        oSpiMiso,
  output logic        oSpiMisoOe,
  output logic        oIrq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Stages [1] are the synchronised levels. Stages [2]
  // (SCK/CS only) hold the previous level for edge detection.
  // ---------------------------------------------------------------------------
  logic [2:0] sck_sync_reg;
  logic [2:0] cs_sync_reg;
  logic [1:0] mosi_sync_reg;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      sck_sync_reg  <= 3'b000;
      cs_sync_reg   <= 3'b111;
      mosi_sync_reg <= 2'b00;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[1:0], iSpiSck};
      cs_sync_reg   <= {cs_sync_reg[1:0], iSpiCsN};
      mosi_sync_reg <= {mosi_sync_reg[0], iSpiMosi};
    end
  end

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_active, mosi_bit;
  assign sck_rise  =  sck_sync_reg[1] & ~sck_sync_reg[2];
  assign sck_fall  = ~sck_sync_reg[1] &  sck_sync_reg[2];
  assign cs_fall   = ~cs_sync_reg[1]  &  cs_sync_reg[2];
  assign cs_rise   =  cs_sync_reg[1]  & ~cs_sync_reg[2];
  assign cs_active = ~cs_sync_reg[1];
  assign mosi_bit  =  mosi_sync_reg[1];

  // ---------------------------------------------------------------------------
  // CPU port decode
  // ---------------------------------------------------------------------------
  logic sel_bc, sel_bd, wr_bc, wr_bd, rd_bc, rd_any;
  assign sel_bc = (iAddr[11:0] == 12'h0BC);
  assign sel_bd = (iAddr[11:0] == 12'h0BD);
  assign wr_bc  = iWr & sel_bc;
  assign wr_bd  = iWr & sel_bd;
  assign rd_bc  = iRd & sel_bc;
  assign rd_any = iRd & (sel_bc | sel_bd);

  // Only the low 12 address bits take part in decoding.
  logic unused_addr;
  assign unused_addr = &{1'b0, iAddr[19:12]};

  // ---------------------------------------------------------------------------
  // Shift engine state
  // ---------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [7:0] shift_reg;
  logic [3:0] bitcnt_reg;
  logic [7:0] tx_hold_reg;
  logic       tx_full_reg;
  logic       irq_en_reg;
  logic       rx_overrun_reg;
  logic       miso_reg;
  logic       miso_oe_reg;

  logic       do_load, do_shift, do_present;
  logic       push, push_ok, pop;
  logic [7:0] load_byte, rx_byte_in, rx_head;
  logic [2:0] rx_count;
  logic       rx_avail;

  assign load_byte  = tx_full_reg ? tx_hold_reg : 8'hFF;
  assign rx_byte_in = {shift_reg[6:0], mosi_bit};
  assign push       = do_shift & (bitcnt_reg == 4'd7);
  assign rx_avail   = (rx_count != 3'd0);
  assign pop        = rd_bc & rx_avail;

  always_comb begin
    state_next = state_reg;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    do_present = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        do_load    = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sck_rise && bitcnt_reg < 4'd8) begin
          do_shift = 1'b1;
        end else if (sck_fall) begin
          // The fall after the 8th rise starts the next byte.
          if (bitcnt_reg == 4'd8) do_load    = 1'b1;
          else                    do_present = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // CS release aborts whatever is in progress; a partial byte is lost.
    if (cs_rise) begin
      state_next = ST_IDLE;
      do_load    = 1'b0;
      do_shift   = 1'b0;
      do_present = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= 8'hFF;
      bitcnt_reg  <= 4'd0;
      miso_reg    <= 1'b1;
      miso_oe_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      miso_oe_reg <= (state_next != ST_IDLE);
      if (do_load) begin
        shift_reg  <= load_byte;
        miso_reg   <= load_byte[7];
        bitcnt_reg <= 4'd0;
      end else if (do_shift) begin
        shift_reg  <= rx_byte_in;
        bitcnt_reg <= bitcnt_reg + 4'd1;
      end else if (do_present) begin
        miso_reg <= shift_reg[7];
      end
      if (state_next == ST_IDLE) miso_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // TX holding register. A CPU write in the same cycle as a load wins the
  // flag: the shifter takes the old value and the new one stays pending.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      tx_hold_reg <= 8'h00;
      tx_full_reg <= 1'b0;
    end else if (wr_bc) begin
      tx_hold_reg <= iData;
      tx_full_reg <= 1'b1;
    end else if (do_load) begin
      tx_full_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Control / overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      irq_en_reg     <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (wr_bd) irq_en_reg <= iData[0];
      // A new overrun in the same cycle as a clear is kept.
      if (push && !push_ok)      rx_overrun_reg <= 1'b1;
      else if (wr_bd && iData[2]) rx_overrun_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX storage. A pop in the same cycle frees room for the push.
  // ---------------------------------------------------------------------------
`ifdef SPI_TARGET_RXFIFO_EN
  logic [7:0] rx_mem [0:3];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] rx_count_reg;

  assign push_ok  = push & ((rx_count_reg != 3'd4) | pop);
  assign rx_count = rx_count_reg;
  assign rx_head  = rx_mem[rd_ptr_reg];

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      wr_ptr_reg   <= 2'd0;
      rd_ptr_reg   <= 2'd0;
      rx_count_reg <= 3'd0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 2'd1;
      rx_count_reg <= rx_count_reg + {2'b00, push_ok} - {2'b00, pop};
    end
  end

  always_ff @(posedge iClk) begin
    if (push_ok) rx_mem[wr_ptr_reg] <= rx_byte_in;
  end
`else
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;

  assign push_ok  = push & (~rx_valid_reg | pop);
  assign rx_count = {2'b00, rx_valid_reg};
  assign rx_head  = rx_data_reg;

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
    end else if (push_ok) begin
      rx_data_reg  <= rx_byte_in;
      rx_valid_reg <= 1'b1;
    end else if (pop) begin
      rx_valid_reg <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // CPU read path
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      oData <= 8'h00;
      oSel  <= 1'b0;
    end else begin
      oSel <= rd_any;
      if (rd_any) begin
        if (sel_bc) oData <= rx_avail ? rx_head : 8'hFF;
        else        oData <= {1'b0, rx_count, cs_active, rx_overrun_reg,
                              ~tx_full_reg, rx_avail};
      end
    end
  end

  assign oSpiMiso   = miso_reg;
  assign oSpiMisoOe = miso_oe_reg;
  assign oIrq       = irq_en_reg & rx_avail;

endmodule

// File: tb/tb_spi_target_port.sv
// Bench for spi_target_port: randomised SPI/CPU traffic against a queue-based
// model of the port behaviour.

module tb_spi_target_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] addr;
  logic        wr, rd;
  logic [7:0]  wdata, rdata;
  logic        sel;
  logic        sck, mosi, cs_n;
  logic        miso, miso_oe, irq;

  always #5 clk = ~clk;

  spi_target_port dut (
    .iClk(clk), .iRstN(rst_n), .iAddr(addr), .iWr(wr), .iRd(rd),
    .iData(wdata), .oData(rdata), .oSel(sel),
    .iSpiSck(sck), .iSpiMosi(mosi), .iSpiCsN(cs_n),
    .oSpiMiso(miso), .oSpiMisoOe(miso_oe), .oIrq(irq)
  );

`ifdef SPI_TARGET_RXFIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int H = 5;  // SCK half period in iClk cycles

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_rxq[$];
  bit         m_ovr, m_txf, m_irq;
  logic [7:0] m_txh, m_cur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_load();
    logic [7:0] v;
    v = m_txf ? m_txh : 8'hFF;
    m_txf = 1'b0;
    return v;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [7:0] m_pop();
    if (m_rxq.size() == 0) return 8'hFF;
    return m_rxq.pop_front();
  endfunction

  function automatic logic [7:0] m_status(input bit cs_act);
    logic [2:0] cnt;
    cnt = 3'(m_rxq.size());
    return {1'b0, cnt, cs_act, m_ovr, ~m_txf, (m_rxq.size() != 0)};
  endfunction

  function automatic void m_reset();
    m_rxq.delete();
    m_ovr = 0; m_txf = 0; m_irq = 0; m_txh = 8'h00;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
    addr = {8'h00, a}; wdata = d; wr = 1'b1;
    tick(1);
    wr = 1'b0;
    if (a == 12'h0BC) begin m_txh = d; m_txf = 1'b1; end
    if (a == 12'h0BD) begin m_irq = d[0]; if (d[2]) m_ovr = 1'b0; end
  endtask

  task automatic cpu_rd(input logic [11:0] a, output logic [7:0] d);
    addr = {8'h00, a}; rd = 1'b1;
    tick(1);
    rd = 1'b0;
    chk("rd_sel", sel, 1'b1);
    d = rdata;
  endtask

  task automatic rd_status(input string tag, input bit cs_act);
    logic [7:0] d;
    logic [7:0] e;
    e = m_status(cs_act);
    cpu_rd(12'h0BD, d);
    chk(tag, d, e);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    e = m_pop();
    cpu_rd(12'h0BC, d);
    chk(tag, d, e);
  endtask

  task automatic drain(input string tag);
    while (m_rxq.size() != 0) pop_chk(tag);
  endtask

  task automatic chk_irq(input string tag);
    chk(tag, irq, (m_irq && m_rxq.size() != 0));
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    m_cur = m_load();
    tick(H);
    chk("oe_active", miso_oe, 1'b1);
  endtask

  task automatic cs_end();
    tick(H);
    cs_n = 1'b1;
    tick(5);
    chk("oe_idle", miso_oe, 1'b0);
  endtask

  // One full byte. With pop_last, a CPU pop of 0BCh is timed to land on the
  // same clock as the byte's RX push.
  task automatic spi_byte(input logic [7:0] b, input bit pop_last);
    logic [7:0] got;
    logic [7:0] d;
    logic [7:0] e;
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      tick(H);
      got[i] = miso;
      sck = 1'b1;
      if (pop_last && i == 0) begin
        tick(2);
        addr = 20'h000BC; rd = 1'b1;
        tick(1);
        rd = 1'b0;
        chk("race_sel", sel, 1'b1);
        e = m_pop();
        chk("race_pop", rdata, e);
        tick(H - 3);
      end else begin
        tick(H);
      end
      sck = 1'b0;
    end
    chk("miso_byte", got, m_cur);
    m_push(b);
    m_cur = m_load();
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom_range(1, 0));
      tick(H);
      sck = 1'b1;
      tick(H);
      sck = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] d;
    int n, np;
    rst_n = 1'b0; addr = '0; wr = 0; rd = 0; wdata = '0;
    sck = 0; mosi = 0; cs_n = 1;
    m_reset();
    tick(3);
    rst_n = 1'b1;
    chk("rst_odata", rdata, 8'h00);
    chk("rst_osel", sel, 1'b0);
    chk("rst_miso", miso, 1'b1);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_irq", irq, 1'b0);
    tick(2);
    rd_status("rst_status", 1'b0);

    // Basic exchange: A5h out, 3Ch in
    cpu_wr(12'h0BC, 8'hA5);
    cs_begin();
    rd_status("cs_status", 1'b1);
    spi_byte(8'h3C, 1'b0);
    cs_end();
    rd_status("t1_status", 1'b0);
    pop_chk("t1_pop");
    rd_status("t1_status2", 1'b0);

    // No TX data: FFh on every byte
    cs_begin();
    spi_byte(8'($urandom), 1'b0);
    spi_byte(8'($urandom), 1'b0);
    cs_end();
    drain("notx_pop");
    pop_chk("empty_pop");

    // Back-to-back 01h..05h with irq enabled and no reads
    cpu_wr(12'h0BD, 8'h01);
    cs_begin();
    for (int k = 1; k <= 5; k++) spi_byte(8'(k), 1'b0);
    cs_end();
    chk_irq("burst_irq");
    rd_status("burst_status", 1'b0);
    drain("burst_pop");
    chk_irq("burst_irq_empty");
    cpu_wr(12'h0BD, 8'h05);
    rd_status("ovr_clear", 1'b0);

    // Partial byte then a full 7Eh
    cs_begin();
    spi_bits(5);
    cs_end();
    cs_begin();
    spi_byte(8'h7E, 1'b0);
    cs_end();
    rd_status("partial_status", 1'b0);
    drain("partial_pop");

    // FIFO full, CPU pop coinciding with the push of 99h
    cs_begin();
    for (int k = 1; k <= DEPTH; k++) spi_byte(8'(8'h11 * k), 1'b0);
    spi_byte(8'h99, 1'b1);
    cs_end();
    rd_status("race_status", 1'b0);
    drain("race_drain");

    // Randomised traffic
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(1, 0) == 1) cpu_wr(12'h0BC, 8'($urandom));
      if ($urandom_range(3, 0) == 0) cpu_wr(12'h0BC, 8'($urandom));
      cs_begin();
      n = $urandom_range(3, 1);
      for (int k = 0; k < n; k++) spi_byte(8'($urandom), 1'b0);
      cs_end();
      chk_irq("rnd_irq");
      rd_status("rnd_status", 1'b0);
      np = $urandom_range(2, 0);
      for (int k = 0; k < np; k++) pop_chk("rnd_pop");
      if ($urandom_range(2, 0) == 0)
        cpu_wr(12'h0BD, {5'b0, 1'b1, 1'b0, 1'($urandom_range(1, 0))});
    end

    // Reset in the middle of a transfer
    drain("pre_rst_drain");
    cpu_wr(12'h0BD, 8'h01);
    cpu_wr(12'h0BC, 8'h5A);
    cs_begin();
    spi_byte(8'hC3, 1'b0);
    chk_irq("pre_rst_irq");
    spi_bits(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_reset();
    chk("midrst_oe", miso_oe, 1'b0);
    chk("midrst_irq", irq, 1'b0);
    cs_n = 1'b1;
    tick(6);
    rd_status("midrst_status", 1'b0);
    cpu_wr(12'h0BC, 8'h81);
    cs_begin();
    spi_byte(8'h42, 1'b0);
    cs_end();
    rd_status("post_rst_status", 1'b0);
    pop_chk("post_rst_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
